// File: rtl/keccak_chi_sched.sv
// keccak_chi_sched
// Sequencer for the masked two-share Keccak chi layer. It loads a 1600-bit
// state as two Boolean shares and streams it chunk by chunk through an
// external registered chi datapath with a fixed latency. Each chunk pulls
// fresh randomness from the PRNG. The returned output shares are written
// back in place, and the result is then presented on a valid/ready port.
//
// Ports
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_in_valid / o_in_ready          state input handshake
//   i_in_share0/1  [1599:0]          input shares (S-box reordered)
//   i_rnd_valid / o_rnd_ready        PRNG handshake
//   i_rnd_data     [RAND_W-1:0]      randomness for one chunk
//   o_chi_issue                      chunk presented to the datapath
//   o_chi_din_0/1  [5S-1:0]          chunk shares (zero when not issuing)
//   o_chi_rand     [RAND_W-1:0]      chunk randomness (zero when not issuing)
//   i_chi_dout_0/1 [5S-1:0]          datapath result, LAT cycles after issue
//   o_out_valid / i_out_ready        result handshake
//   o_out_share0/1 [1599:0]          result shares (zero outside DONE)
//   o_busy                           any state other than IDLE
module keccak_chi_sched #(
    parameter int SBOX_PER_CYCLE = 64,
    parameter int LAT            = 1,
    parameter int RAND_W         = 10 * SBOX_PER_CYCLE
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [1599:0]               i_in_share0,
    input  logic [1599:0]               i_in_share1,
    input  logic                        i_rnd_valid,
    output logic                        o_rnd_ready,
    input  logic [RAND_W-1:0]           i_rnd_data,
    output logic                        o_chi_issue,
    output logic [5*SBOX_PER_CYCLE-1:0] o_chi_din_0,
    output logic [5*SBOX_PER_CYCLE-1:0] o_chi_din_1,
    output logic [RAND_W-1:0]           o_chi_rand,
    input  logic [5*SBOX_PER_CYCLE-1:0] i_chi_dout_0,
    input  logic [5*SBOX_PER_CYCLE-1:0] i_chi_dout_1,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [1599:0]               o_out_share0,
    output logic [1599:0]               o_out_share1,
    output logic                        o_busy
);

    localparam int W      = 5 * SBOX_PER_CYCLE;
    localparam int NCHUNK = 320 / SBOX_PER_CYCLE;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] C_FULL = CW'(NCHUNK);
    localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1599:0]   r_buf0;
    logic [1599:0]   r_buf1;
    logic [CW-1:0]   r_issue_idx;
    logic [CW-1:0]   r_ret_idx;
    logic [LAT-1:0]  r_vpipe;
    logic            w_issue;
    logic            w_ret;
    logic [CW-1:0]   w_ret_next;
    logic [W-1:0]    w_sel0;
    logic [W-1:0]    w_sel1;

    // An issue needs the ISSUE state, a PRNG word, and a chunk still left to send.
    assign w_issue = (r_state == S_ISSUE) && i_rnd_valid && (r_issue_idx != C_FULL);
    // The tail of the valid pipe marks the cycle when the datapath result is present.
    assign w_ret   = r_vpipe[LAT-1];
    // This is the return count after this cycle, so DRAIN can leave in the same
    // cycle that the final chunk is captured.
    assign w_ret_next = (w_ret && (r_ret_idx != C_FULL)) ? (r_ret_idx + C_ONE) : r_ret_idx;

    // Chunk select for issue: an AND-OR mux over the chunk slots of each share.
    always_comb begin
        w_sel0 = '0;
        w_sel1 = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            w_sel0 = w_sel0 | (r_buf0[k*W +: W] & {W{r_issue_idx == CW'(k)}});
            w_sel1 = w_sel1 | (r_buf1[k*W +: W] & {W{r_issue_idx == CW'(k)}});
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) w_next = S_ISSUE;
                else            w_next = S_IDLE;
            end
            S_ISSUE: begin
                if (w_issue && (r_issue_idx == C_LAST)) w_next = S_DRAIN;
                else                                    w_next = S_ISSUE;
            end
            S_DRAIN: begin
                if (w_ret_next == C_FULL) w_next = S_DONE;
                else                      w_next = S_DRAIN;
            end
            S_DONE: begin
                if (i_out_ready) w_next = S_IDLE;
                else             w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Share buffers, counters and the in-flight valid pipe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_issue_idx <= '0;
            r_ret_idx   <= '0;
            r_vpipe     <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            if ((r_state == S_IDLE) && i_in_valid) begin
                r_buf0      <= i_in_share0;
                r_buf1      <= i_in_share1;
                r_issue_idx <= '0;
                r_ret_idx   <= '0;
            end else if ((r_state == S_DONE) && i_out_ready) begin
                // Do not leave the result shares behind once they have been handed off.
                r_buf0 <= '0;
                r_buf1 <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_idx <= r_issue_idx + C_ONE;
                end
                if (w_ret && (r_ret_idx != C_FULL)) begin
                    r_ret_idx <= r_ret_idx + C_ONE;
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (r_ret_idx == CW'(k)) begin
                            r_buf0[k*W +: W] <= i_chi_dout_0;
                            r_buf1[k*W +: W] <= i_chi_dout_1;
                        end
                    end
                end
            end
        end
    end

    // The datapath inputs stay at zero unless a chunk is being issued, so idle
    // cycles carry no share data.
    assign o_chi_issue  = w_issue;
    assign o_chi_din_0  = w_issue ? w_sel0 : '0;
    assign o_chi_din_1  = w_issue ? w_sel1 : '0;
    assign o_chi_rand   = w_issue ? i_rnd_data : '0;

    assign o_in_ready   = (r_state == S_IDLE);
    assign o_rnd_ready  = (r_state == S_ISSUE);
    assign o_out_valid  = (r_state == S_DONE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_out_share0 = (r_state == S_DONE) ? r_buf0 : '0;
    assign o_out_share1 = (r_state == S_DONE) ? r_buf1 : '0;

endmodule

// File: tb/tb_keccak_chi_sched.sv
`timescale 1ns/1ps
// Testbench for keccak_chi_sched. It drives a default-parameter instance
// (64 S-boxes per issue, LAT=1) and a single-chunk instance (320 S-boxes,
// LAT=3). Each instance has a behavioural masked-chi datapath. Expected
// results go into queues, and monitors compare them against the outputs.
module tb_keccak_chi_sched;

    typedef struct {
        logic [1599:0] x;
        int            c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Default-parameter instance signals.
    logic          in_valid, in_ready, rnd_valid, rnd_ready, chi_issue;
    logic          out_valid, out_ready, busy;
    logic [1599:0] in_s0, in_s1, out_s0, out_s1;
    logic [639:0]  rnd_data, chi_rand;
    logic [319:0]  din0, din1, dout0, dout1;
    logic [3199:0] m1_res;

    // Single-chunk LAT=3 instance signals.
    logic          in_valid2, in_ready2, rnd_valid2, rnd_ready2, chi_issue2;
    logic          out_valid2, out_ready2, busy2;
    logic [1599:0] in2_s0, in2_s1, out2_s0, out2_s1, din2_0, din2_1, dout2_0, dout2_1;
    logic [3199:0] rnd_data2, chi_rand2, m2_res;
    logic [1599:0] p2_0 [3];
    logic [1599:0] p2_1 [3];

    // Bench state that the stimulus and the monitors share.
    exp_t          q[$];
    exp_t          q2[$];
    logic [1599:0] cur_s0, cur_s1, hold0, hold1, last0, lastx;
    int            iss_k = 0, rnd_cnt = 0, hs_cnt = 0, acc_cyc = 0;
    int            iss2 = 0, drain2 = 0, hs2 = 0, acc2 = 0;
    bit            stall_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_chi_sched u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_share0(in_s0), .i_in_share1(in_s1),
        .i_rnd_valid(rnd_valid), .o_rnd_ready(rnd_ready), .i_rnd_data(rnd_data),
        .o_chi_issue(chi_issue), .o_chi_din_0(din0), .o_chi_din_1(din1),
        .o_chi_rand(chi_rand), .i_chi_dout_0(dout0), .i_chi_dout_1(dout1),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_share0(out_s0), .o_out_share1(out_s1), .o_busy(busy)
    );

    keccak_chi_sched #(.SBOX_PER_CYCLE(320), .LAT(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid2), .o_in_ready(in_ready2),
        .i_in_share0(in2_s0), .i_in_share1(in2_s1),
        .i_rnd_valid(rnd_valid2), .o_rnd_ready(rnd_ready2), .i_rnd_data(rnd_data2),
        .o_chi_issue(chi_issue2), .o_chi_din_0(din2_0), .o_chi_din_1(din2_1),
        .o_chi_rand(chi_rand2), .i_chi_dout_0(dout2_0), .i_chi_dout_1(dout2_1),
        .o_out_valid(out_valid2), .i_out_ready(out_ready2),
        .o_out_share0(out2_s0), .o_out_share1(out2_s1), .o_busy(busy2)
    );

    function automatic logic [4:0] chi5(input logic [4:0] x);
        logic [4:0] y;
        for (int i = 0; i < 5; i++) y[i] = x[i] ^ (~x[(i+1)%5] & x[(i+2)%5]);
        return y;
    endfunction

    // Behavioural masked chi. Share 0 is chi(x) XOR r and share 1 is r, so the
    // output shares depend on the randomness.
    function automatic logic [3199:0] dp_model(input logic [1599:0] a, input logic [1599:0] b,
                                               input logic [3199:0] r, input int nbox);
        logic [1599:0] o0, o1;
        logic [4:0]    m;
        o0 = '0;
        o1 = '0;
        for (int g = 0; g < nbox; g++) begin
            m = r[10*g +: 5];
            o0[5*g +: 5] = chi5(a[5*g +: 5] ^ b[5*g +: 5]) ^ m;
            o1[5*g +: 5] = m;
        end
        return {o1, o0};
    endfunction

    function automatic logic [3199:0] rand3200();
        logic [3199:0] r;
        for (int i = 0; i < 100; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] fold64(input logic [1599:0] v);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 25; i++) f = f ^ v[i*64 +: 64];
        return f;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Datapath models. One is LAT=1 and captures on issue. The other is LAT=3
    // and is always shifting.
    always_comb m1_res = dp_model({1280'b0, din0}, {1280'b0, din1}, {2560'b0, chi_rand}, 64);
    always_comb m2_res = dp_model(din2_0, din2_1, chi_rand2, 320);
    always @(posedge clk) begin
        if (chi_issue) begin
            dout0 <= m1_res[319:0];
            dout1 <= m1_res[1919:1600];
        end
        p2_0[0] <= m2_res[1599:0];
        p2_1[0] <= m2_res[3199:1600];
        p2_0[1] <= p2_0[0];
        p2_1[1] <= p2_1[0];
        p2_0[2] <= p2_0[1];
        p2_1[2] <= p2_1[1];
    end
    assign dout2_0 = p2_0[2];
    assign dout2_1 = p2_1[2];

    // PRNG driver. It can stall on cycles 2 and 4 after an accept.
    initial begin : prng
        logic [3199:0] rt;
        rnd_valid = 1'b0; rnd_valid2 = 1'b0; rnd_data = '0; rnd_data2 = '0;
        forever begin
            @(posedge clk); #2;
            rt = rand3200();
            rnd_data  = rt[639:0];
            rnd_valid = !(stall_en && ((cyc == acc_cyc + 2) || (cyc == acc_cyc + 4)));
            rnd_data2 = rand3200();
            rnd_valid2 = 1'b1;
        end
    end

    // Monitor and scoreboard for the default instance.
    initial begin : mon1
        exp_t e;
        bit   prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (chi_issue) begin
                    chk(iss_k < 5, "issue_index", 64'(iss_k), 64'd4);
                    chk(din0 == cur_s0[iss_k*320 +: 320], "issue_din0", din0[63:0], cur_s0[iss_k*320 +: 64]);
                    chk(din1 == cur_s1[iss_k*320 +: 320], "issue_din1", din1[63:0], cur_s1[iss_k*320 +: 64]);
                    chk(chi_rand == rnd_data, "issue_rand", chi_rand[63:0], rnd_data[63:0]);
                    iss_k++;
                end else begin
                    chk((din0 == '0) && (din1 == '0) && (chi_rand == '0), "noissue_zero",
                        din0[63:0] | din1[63:0] | chi_rand[63:0], 64'd0);
                end
                if (rnd_valid && rnd_ready) rnd_cnt++;
                if (out_valid && !prev_ov) begin
                    chk(q.size() != 0, "out_expected", 64'(q.size()), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk(cyc == e.c, "out_valid_cycle", 64'(cyc - acc_cyc), 64'(e.c - acc_cyc));
                        chk((out_s0 ^ out_s1) == e.x, "out_xor", fold64(out_s0 ^ out_s1), fold64(e.x));
                        chk(rnd_cnt == 5, "rnd_handshakes", 64'(rnd_cnt), 64'd5);
                        chk(iss_k == 5, "issue_total", 64'(iss_k), 64'd5);
                    end
                    hold0 = out_s0;
                    hold1 = out_s1;
                    last0 = out_s0;
                    lastx = out_s0 ^ out_s1;
                end else if (out_valid) begin
                    chk((out_s0 == hold0) && (out_s1 == hold1), "out_stable", fold64(out_s0), fold64(hold0));
                end
                if (out_valid) chk(!in_ready, "in_ready_low_in_done", 64'(in_ready), 64'd0);
                else chk((out_s0 == '0) && (out_s1 == '0), "out_zero_outside_done", fold64(out_s0 | out_s1), 64'd0);
                if (out_valid && out_ready) hs_cnt++;
                prev_ov = out_valid;
            end
        end
    end

    // Monitor and scoreboard for the single-chunk LAT=3 instance.
    initial begin : mon2
        exp_t e;
        bit   prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (chi_issue2) begin
                    chk(cyc == acc2 + 1, "dut2_issue_cycle", 64'(cyc - acc2), 64'd1);
                    chk((din2_0 == in2_s0) && (din2_1 == in2_s1), "dut2_issue_din", fold64(din2_0), fold64(in2_s0));
                    iss2++;
                end else begin
                    chk((din2_0 == '0) && (din2_1 == '0) && (chi_rand2 == '0), "dut2_noissue_zero",
                        fold64(din2_0 | din2_1), 64'd0);
                end
                if (busy2 && !rnd_ready2 && !out_valid2) drain2++;
                if (out_valid2 && !prev_ov) begin
                    chk(q2.size() != 0, "dut2_out_expected", 64'(q2.size()), 64'd1);
                    if (q2.size() != 0) begin
                        e = q2.pop_front();
                        chk(cyc == e.c, "dut2_out_valid_cycle", 64'(cyc - acc2), 64'(e.c - acc2));
                        chk((out2_s0 ^ out2_s1) == e.x, "dut2_out_xor", fold64(out2_s0 ^ out2_s1), fold64(e.x));
                        chk(drain2 == 3, "dut2_drain_cycles", 64'(drain2), 64'd3);
                        chk(iss2 == 1, "dut2_issue_total", 64'(iss2), 64'd1);
                    end
                end
                if (out_valid2 && out_ready2) hs2++;
                prev_ov = out_valid2;
            end
        end
    end

    task automatic start(input logic [1599:0] s0, input logic [1599:0] s1,
                         input logic [1599:0] ex, input int lat);
        exp_t e;
        @(posedge clk); #1;
        cur_s0 = s0; cur_s1 = s1; iss_k = 0; rnd_cnt = 0;
        in_s0 = s0; in_s1 = s1; in_valid = 1'b1;
        acc_cyc = cyc;
        e.x = ex; e.c = cyc + lat;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (hs_cnt >= target) break;
        end
        chk(hs_cnt >= target, nm, 64'(hs_cnt), 64'(target));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1599:0] p06, p16, p01, p09, p1f, mk, mk2, r1, x1;
        logic [3199:0] rt;
        exp_t          e;
        p06 = {320{5'h06}}; p16 = {320{5'h16}};
        p01 = {320{5'h01}}; p09 = {320{5'h09}};
        p1f = {320{5'h1f}};
        rt = rand3200(); mk = rt[1599:0]; mk2 = rt[3199:1600];
        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        in_s0 = '0; in_s1 = '0; in2_s0 = '0; in2_s1 = '0; cur_s0 = '0; cur_s1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        chk({rnd_ready, chi_issue, out_valid, busy} == 4'b0, "rst_ctrl", 64'({rnd_ready, chi_issue, out_valid, busy}), 64'd0);
        chk((out_s0 == '0) && (out_s1 == '0) && (din0 == '0) && (chi_rand == '0), "rst_data", fold64(out_s0), 64'd0);
        chk({in_ready2, rnd_ready2, out_valid2, busy2} == 4'b1000, "rst_dut2", 64'({in_ready2, rnd_ready2, out_valid2, busy2}), 64'h8);
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal run: share 0 is zero, and every group unmasks to 0x06 -> chi 0x16.
        start('0, p06, p16, 7);
        wait_hs(1, "nominal_handshake");

        // PRNG stalls on cycles 2 and 4 add two cycles.
        stall_en = 1'b1;
        start(mk, mk ^ p06, p16, 9);
        wait_hs(2, "stall_handshake");
        stall_en = 1'b0;

        // Output backpressure: out_ready is held low for 10 cycles in DONE.
        out_ready = 1'b0;
        start(mk2, mk2 ^ p01, p09, 7);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk(out_valid == 1'b1, "bp_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_hs(3, "bp_handshake");
        #1;
        chk(in_ready == 1'b1, "bp_in_ready_after", 64'(in_ready), 64'd1);
        chk((out_s0 == '0) && (out_s1 == '0), "bp_zeroized", fold64(out_s0 | out_s1), 64'd0);

        // Reset asserted in cycle 3 of an operation.
        start(mk, mk ^ p06, p16, 7);
        repeat (acc_cyc + 3 - cyc) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 64'd1);
        chk({rnd_ready, chi_issue, out_valid, busy} == 4'b0, "midrst_ctrl", 64'({rnd_ready, chi_issue, out_valid, busy}), 64'd0);
        chk((din0 == '0) && (chi_rand == '0) && (out_s0 == '0), "midrst_data", fold64(out_s0), 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start(mk2, mk2 ^ p01, p09, 7);
        wait_hs(4, "after_reset_handshake");

        // The same shares with different randomness give different shares but the same XOR.
        start(mk, mk ^ p01, p09, 7);
        wait_hs(5, "indep_run1");
        r1 = last0; x1 = lastx;
        start(mk, mk ^ p01, p09, 7);
        wait_hs(6, "indep_run2");
        chk(last0 != r1, "indep_share_differs", fold64(last0), ~fold64(r1));
        chk(lastx == x1, "indep_xor_same", fold64(lastx), fold64(x1));

        // Single-chunk instance with LAT=3.
        @(posedge clk); #1;
        in2_s0 = mk; in2_s1 = ~mk; in_valid2 = 1'b1; iss2 = 0; drain2 = 0;
        acc2 = cyc;
        e.x = p1f; e.c = cyc + 5;
        q2.push_back(e);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (hs2 >= 1) break;
        end
        chk(hs2 >= 1, "dut2_handshake", 64'(hs2), 64'd1);

        repeat (3) @(posedge clk);
        chk((q.size() == 0) && (q2.size() == 0), "scoreboard_drained", 64'(q.size() + q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
